// File: rtl/data_mem_slave_pkg.sv
// Shared definitions for the data-memory responder: bus widths, wait-counter
// width and the FSM state encoding.
package data_mem_slave_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_slave_array.sv
// Word-organised data storage with byte-lane writes and a registered read port.
// The array is named mem so hierarchical preload paths stay stable.
module dmem_array
    import data_mem_slave_pkg::*;
#(
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // NOTE: storage and its read register have no reset; clearing a RAM needs
    // a sequencer, and the responder masks rdata until a load has completed.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_slave.sv
// Data-memory responder for the core's req/gnt/rvalid port: programmable wait
// states, address range check and one registered response per grant.
module data_mem_slave
    import data_mem_slave_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_req_i,
    output logic              data_gnt_o,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic              data_we_i,
    input  logic [BE_W-1:0]   data_be_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_rvalid_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_err_o
);

    localparam int                AW        = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              gnt_fsm;
    logic              gnt;
    logic [ADDR_W-1:0] offset;
    logic              in_range;
    logic              rvalid_q;
    logic              err_q;
    logic              load_q;
    logic [DATA_W-1:0] array_rdata;
    logic              unused_offset_lsbs;

    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign offset             = data_addr_i - BASE_ADDR;
    assign in_range           = (offset[ADDR_W-1:AW+2] == '0);
    assign unused_offset_lsbs = ^offset[1:0];

    // NOTE: every variable written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = ST_IDLE;
        wait_cnt_d = wait_cnt_q;
        gnt_fsm    = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_RESP: begin
                if (data_req_i) begin
                    if (WAIT_CYCLES == 0) begin
                        gnt_fsm = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        wait_cnt_d = WAIT_INIT;
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q - 1'b1;
                if (!data_req_i) begin
                    wait_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    gnt_fsm = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grant is combinational, so it is gated by reset to keep the output low
    // and to stop the array committing a write while reset is held.
    assign gnt        = gnt_fsm & rst_n;
    assign data_gnt_o = gnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rvalid_q   <= gnt;
            if (gnt) begin
                err_q  <= ~in_range;
                load_q <= in_range & ~data_we_i;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .en    (gnt & in_range),
        .we    (data_we_i),
        .be    (data_be_i),
        .addr  (offset[AW+1:2]),
        .wdata (data_wdata_i),
        .rdata (array_rdata)
    );

    // Read data shows only after an in-range load; stores and errors give 0.
    assign data_rvalid_o = rvalid_q;
    assign data_err_o    = err_q;
    assign data_rdata_o  = load_q ? array_rdata : '0;

endmodule

// File: tb/tb_data_mem_slave.sv
// Self-checking bench: two responders (no wait states at base 0, three wait
// states at a non-zero base) checked against a word-array reference model.
module tb_data_mem_slave;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE3 = 32'h0001_0000;

    logic        clk;
    logic        rst_n;
    logic        req    [2];
    logic        we     [2];
    logic [3:0]  be     [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic        gnt    [2];
    logic        rvalid [2];
    logic        err    [2];
    logic [31:0] rdata  [2];

    logic [31:0] model_mem [2][DEPTH];
    int          n_checks;
    int          n_errors;

    data_mem_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE0), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(req[0]), .data_gnt_o(gnt[0]), .data_addr_i(addr[0]),
        .data_we_i(we[0]), .data_be_i(be[0]), .data_wdata_i(wdata[0]),
        .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0])
    );

    data_mem_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE3), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(req[1]), .data_gnt_o(gnt[1]), .data_addr_i(addr[1]),
        .data_we_i(we[1]), .data_be_i(be[1]), .data_wdata_i(wdata[1]),
        .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? BASE0 : BASE3;
    endfunction

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // One complete transaction: latency, single response, data/err and hold.
    task automatic access(input int d, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] wd,
                          output logic [31:0] got);
        int          n;
        logic [31:0] off;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [9:0]  idx;
        off     = a - base_of(d);
        exp_err = !(off < 32'(DEPTH * 4));
        idx     = off[11:2];
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
        n = 0;
        #1;
        while (!gnt[d] && n < 40) begin
            @(negedge clk);
            n++;
            #1;
        end
        check("gnt_latency", 32'(n), 32'(wait_of(d)));
        exp_rd = '0;
        if (!exp_err) begin
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) model_mem[d][idx][8*i +: 8] = wd[8*i +: 8];
            end else begin
                exp_rd = model_mem[d][idx];
            end
        end
        @(negedge clk);
        req[d] = 1'b0; we[d] = $urandom; addr[d] = $urandom; be[d] = $urandom; wdata[d] = $urandom;
        #1;
        got = rdata[d];
        check("rvalid", {31'b0, rvalid[d]}, 32'd1);
        check("err", {31'b0, err[d]}, {31'b0, exp_err});
        if (!w || exp_err) check("rdata", rdata[d], exp_rd);
        @(negedge clk);
        #1;
        check("rvalid_single", {31'b0, rvalid[d]}, 32'd0);
        check("err_hold", {31'b0, err[d]}, {31'b0, exp_err});
        if (!w || exp_err) check("rdata_hold", rdata[d], exp_rd);
    endtask

    // Request on the stalled responder that is withdrawn before the grant.
    task automatic abort_store(input int hold, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = a; be[1] = 4'hF; wdata[1] = wd;
        for (int j = 0; j < hold; j++) begin
            #1;
            check("abort_no_gnt", {31'b0, gnt[1]}, 32'd0);
            @(negedge clk);
        end
        req[1] = 1'b0;
        #1;
        check("abort_no_gnt_drop", {31'b0, gnt[1]}, 32'd0);
        @(negedge clk);
        #1;
        check("abort_no_rvalid", {31'b0, rvalid[1]}, 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [3:0]  b;
        logic        w;
        int          d;
        int          word;

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; be[i] = '0; addr[i] = '0; wdata[i] = '0;
        end

        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_gnt", {31'b0, gnt[i]}, 32'd0);
            check("reset_rvalid", {31'b0, rvalid[i]}, 32'd0);
            check("reset_rdata", rdata[i], 32'd0);
            check("reset_err", {31'b0, err[i]}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Preload words 0..15 of both responders through ordinary stores.
        for (int dd = 0; dd < 2; dd++)
            for (int i = 0; i < 16; i++)
                access(dd, 1'b1, base_of(dd) + 32'(i * 4), 4'hF,
                       (i == 4) ? 32'hDEAD_BEEF : $urandom, got);

        access(0, 1'b0, 32'h10, 4'hF, 32'h0, got);
        check("load_deadbeef", got, 32'hDEAD_BEEF);

        access(0, 1'b1, 32'h10, 4'b0010, 32'h0000_5A00, got);
        access(0, 1'b0, 32'h10, 4'hF, 32'h0, got);
        check("byte_store", got, 32'hDEAD_5AEF);

        access(1, 1'b1, BASE3 + 32'h18, 4'hF, 32'h1234_5678, got);
        access(1, 1'b0, BASE3 + 32'h18, 4'hF, 32'h0, got);
        check("stall_load", got, 32'h1234_5678);

        access(0, 1'b1, 32'h8, 4'h0, 32'hFFFF_FFFF, got);
        access(0, 1'b0, 32'h8, 4'hF, 32'h0, got);

        // Four loads with req held high: grants on consecutive cycles.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'(i * 4);
            #1;
            check("b2b_gnt", {31'b0, gnt[0]}, 32'd1);
            if (i > 0) begin
                check("b2b_rvalid", {31'b0, rvalid[0]}, 32'd1);
                check("b2b_rdata", rdata[0], model_mem[0][i-1]);
            end
        end
        @(negedge clk);
        req[0] = 1'b0;
        #1;
        check("b2b_gnt_end", {31'b0, gnt[0]}, 32'd0);
        check("b2b_rvalid_last", {31'b0, rvalid[0]}, 32'd1);
        check("b2b_rdata_last", rdata[0], model_mem[0][3]);
        @(negedge clk);
        #1;
        check("b2b_rvalid_done", {31'b0, rvalid[0]}, 32'd0);

        access(0, 1'b1, 32'h0000_1000, 4'hF, 32'hBAD0_BAD0, got);
        check("oor_rdata", got, 32'd0);
        access(0, 1'b0, 32'h0, 4'hF, 32'h0, got);
        access(1, 1'b0, BASE3 - 32'd4, 4'hF, 32'h0, got);

        abort_store(1, BASE3 + 32'h1C, 32'hA5A5_A5A5);
        abort_store(2, BASE3 + 32'h1C, 32'h5A5A_5A5A);
        access(1, 1'b0, BASE3 + 32'h1C, 4'hF, 32'h0, got);

        // Write granted before reset stays committed; its response is dropped.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h14; be[0] = 4'hF; wdata[0] = 32'hC0FF_EE55;
        #1;
        check("rst_commit_gnt", {31'b0, gnt[0]}, 32'd1);
        model_mem[0][5] = 32'hC0FF_EE55;
        @(negedge clk);
        req[0] = 1'b0;
        #1;
        check("rst_commit_rvalid", {31'b0, rvalid[0]}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_drop_rvalid", {31'b0, rvalid[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        access(0, 1'b0, 32'h14, 4'hF, 32'h0, got);
        check("rst_commit_data", got, 32'hC0FF_EE55);

        // Reset while the stalled responder sits in its wait states.
        access(1, 1'b0, BASE3 + 32'h10, 4'hF, 32'h0, got);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = BASE3 + 32'h8; be[1] = 4'hF;
        @(negedge clk);
        #1;
        check("rst_wait_gnt", {31'b0, gnt[1]}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_rdata", rdata[1], 32'd0);
        check("rst_async_err", {31'b0, err[1]}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst_held_gnt", {31'b0, gnt[1]}, 32'd0);
            check("rst_held_rvalid", {31'b0, rvalid[1]}, 32'd0);
        end
        @(negedge clk);
        req[1] = 1'b0;
        rst_n  = 1'b1;
        access(1, 1'b0, BASE3 + 32'h8, 4'hF, 32'h0, got);

        // Randomised mix of loads, stores, partial enables and bad addresses.
        for (int it = 0; it < 80; it++) begin
            d    = $urandom_range(1, 0);
            w    = 1'($urandom_range(1, 0));
            b    = 4'($urandom);
            word = $urandom_range(15, 0);
            a    = base_of(d) + 32'(word * 4) + 32'($urandom_range(3, 0));
            if ($urandom_range(7, 0) == 0) begin
                a = ($urandom_range(1, 0) == 0) ? base_of(d) + 32'h1000 + 32'($urandom_range(4095, 0))
                                                : base_of(d) - 32'($urandom_range(64, 1));
            end
            if (d == 1 && $urandom_range(5, 0) == 0)
                abort_store($urandom_range(2, 1), a, $urandom);
            access(d, w, a, b, $urandom, got);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_mem_slave.md
# data_mem_slave

Data-memory responder for the RV32IC core's load/store port: it accepts word-aligned load and store requests over the core's req/gnt/rvalid data interface, applies byte-enabled writes, and returns read data. It sits in the core-plus-memory top beside the instruction memory and replaces the bare data sp_ram, adding programmable wait states so the load, store and store-stall paths of the load/store unit can be exercised.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `WAIT_CYCLES`, 0: extra cycles before `data_gnt_o` per request; range 0..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_req_i` in 1: request valid from the load/store unit.
- `data_gnt_o` out 1: request accepted this cycle.
- `data_addr_i` in 32: byte address; bits [1:0] are ignored.
- `data_we_i` in 1: 1 = store, 0 = load.
- `data_be_i` in 4: byte enables, lane i = bits [8i+7:8i].
- `data_wdata_i` in 32: store data, already lane-aligned.
- `data_rvalid_o` out 1: response valid, exactly one per grant.
- `data_rdata_o` out 32: load data, full word; valid only with `data_rvalid_o`.
- `data_err_o` out 1: address out of range; valid only with `data_rvalid_o`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On `data_req_i`=1 with `WAIT_CYCLES`=0, assert `data_gnt_o` in the same cycle, combinationally, and go to RESP.
  - On `data_req_i`=1 with `WAIT_CYCLES`>0, load `wait_cnt`=`WAIT_CYCLES` and go to WAIT.
- WAIT:
  - Decrement `wait_cnt` each cycle.
  - When `wait_cnt`==1 and `data_req_i`=1, assert `data_gnt_o` and go to RESP.
  - If `data_req_i` drops, return to IDLE. No write occurs and no response is issued.
- RESP:
  - `data_rvalid_o`=1 for exactly one cycle.
  - A new request in this cycle follows the IDLE rules, so back-to-back accesses are allowed. Otherwise go to IDLE.
- Grant edge, store, in range: every lane with `data_be_i[i]`=1 is written; other lanes are unchanged. `data_be_i`=0 is a legal no-op.
- Grant edge, load, in range: the full word is registered into `data_rdata_o`.
- Out of range means `data_addr_i - BASE_ADDR >= DEPTH_WORDS*4`, using unsigned 32-bit wrap. On an out-of-range grant: no write, `data_rdata_o`=0, and `data_err_o`=1 together with `data_rvalid_o`.
- Word index is `(data_addr_i - BASE_ADDR)[log2(DEPTH_WORDS)+1:2]`.
- Address, `data_we_i`, `data_be_i` and `data_wdata_i` are sampled only at the grant edge. The initiator holds them stable from req until gnt.
- Read-after-write to the same word on back-to-back grants returns the newly written data.

## Timing
- Reset values: `data_gnt_o`=0, `data_rvalid_o`=0, `data_rdata_o`=0, `data_err_o`=0, state IDLE, `wait_cnt`=0.
- Memory contents are not reset. The testbench preloads the array with `$readmemh` through a hierarchical path.
- Grant latency: `WAIT_CYCLES` cycles after req first rises.
- Response latency: `data_rvalid_o` comes exactly 1 cycle after the grant cycle.
- Throughput: 1 access/cycle at `WAIT_CYCLES`=0; otherwise 1 access per `WAIT_CYCLES`+1 cycles.
- At most one outstanding transaction; `data_gnt_o` and `data_rvalid_o` may be high in the same cycle.
- Reset asserted mid-transaction:
  - Any pending response is dropped and all outputs clear asynchronously.
  - A write whose grant edge has already passed stays committed.
- `data_rdata_o` and `data_err_o` hold their values after `data_rvalid_o` falls until the next response.

## Structure
- Shared header `dmem_defs.vh`: state encodings, `WAIT_W`=4, and the 32-bit address/data widths. It is shared with the instruction-memory wrapper and the testbench.
- Sub-module `dmem_array`:
  - Ports: `DEPTH_WORDS`×32 storage, `clk`, `en`, `we`, `be[3:0]`, `addr`, `wdata`, `rdata`.
  - Synchronous read, byte-lane write.
  - The storage array is named `mem` so testbench `$readmemh` paths stay stable.
- `data_mem_slave` holds only the FSM, the wait counter, the range check and the response registers.

## Test plan
- Load, `WAIT_CYCLES`=0: preload word 4 = 32'hDEADBEEF; load addr 32'h10 → gnt in the req cycle, rvalid next cycle, rdata=32'hDEADBEEF, err=0.
- Byte store: word 4 = 32'hDEADBEEF; store addr 32'h10, be=4'b0010, wdata=32'h0000_5A00; then load 32'h10 → rdata=32'hDEADBEEF with byte 1 replaced, i.e. 32'hDEAD5AEF.
- Stall, `WAIT_CYCLES`=3: store then load the same word → gnt exactly 3 cycles after each req rise, one rvalid per gnt, load returns the stored word.
- Back-to-back: four consecutive loads of words 0..3 with req held high at `WAIT_CYCLES`=0 → four gnts on four consecutive cycles, rvalids on the following four cycles, data in order.
- Out of range, `DEPTH_WORDS`=1024: store to 32'h0000_1000 → rvalid with err=1, rdata=0; memory unchanged (word 0 still reads its preloaded value).
- Reset mid-operation, `WAIT_CYCLES`=3: drop `rst_n` while in WAIT → no gnt, no rvalid, all outputs 0; after release, a fresh load completes normally.
